// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - four-master round-robin bus arbiter with tenure limit
// Optional owner lock inputs are built in when BUS_ARB_LOCK_EN is defined.
module bus_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       M0_req,
    input  logic       M1_req,
    input  logic       M2_req,
    input  logic       M3_req,
`ifdef BUS_ARB_LOCK_EN
    input  logic       M0_lock,
    input  logic       M1_lock,
    input  logic       M2_lock,
    input  logic       M3_lock,
`endif
    output logic       M0_grant,
    output logic       M1_grant,
    output logic       M2_grant,
    output logic       M3_grant,
    output logic [1:0] grant_id,
    output logic       bus_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam bit                LIMIT_OFF = (MAX_HOLD == 0);
    localparam logic [HOLD_W-1:0] LIMIT     = LIMIT_OFF ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_grant;
    logic [3:0]        w_grant_nxt;
    logic [1:0]        r_grant_id;
    logic [1:0]        w_id_nxt;
    logic [1:0]        r_ptr;
    logic [1:0]        w_ptr_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic              r_busy;

    logic [3:0]        w_req;
    logic [3:0]        w_lock;
    logic [3:0]        w_others;
    logic              w_owner_req;
    logic              w_owner_lock;
    logic [2:0]        w_pick_idle;
    logic [2:0]        w_pick_next;

    assign w_req = {M3_req, M2_req, M1_req, M0_req};

`ifdef BUS_ARB_LOCK_EN
    assign w_lock = {M3_lock, M2_lock, M1_lock, M0_lock};
`else
    assign w_lock = 4'b0000;
`endif

    // Returns {found, index} of the first set bit searching upward from start with wrap.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_owner_req  = |(w_req & r_grant);
    assign w_owner_lock = |(w_lock & r_grant);
    assign w_others     = w_req & ~r_grant;
    assign w_pick_idle  = rr_pick(w_req, r_ptr);
    assign w_pick_next  = rr_pick(w_others, r_grant_id + 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_grant_id;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[2]) begin
                    w_state_nxt = ST_OWN;
                    w_grant_nxt = 4'b0001 << w_pick_idle[1:0];
                    w_id_nxt    = w_pick_idle[1:0];
                    w_ptr_nxt   = w_pick_idle[1:0] + 2'd1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_OWN: begin
                if (w_owner_req) begin
                    if (w_owner_lock) begin
                        w_cnt_nxt = r_cnt;
                    end else if ((w_others == 4'b0000) || LIMIT_OFF || (r_cnt < LIMIT)) begin
                        if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        // Tenure expired with another requester waiting; owner is excluded.
                        w_grant_nxt = 4'b0001 << w_pick_next[1:0];
                        w_id_nxt    = w_pick_next[1:0];
                        w_ptr_nxt   = w_pick_next[1:0] + 2'd1;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_pick_next[2]) begin
                    w_grant_nxt = 4'b0001 << w_pick_next[1:0];
                    w_id_nxt    = w_pick_next[1:0];
                    w_ptr_nxt   = w_pick_next[1:0] + 2'd1;
                    w_cnt_nxt   = '0;
                end else begin
                    // grant_id keeps the last owner so the next search starts after it.
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'd0;
            r_ptr      <= 2'd0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= |w_grant_nxt;
        end
    end

    assign M0_grant = r_grant[0];
    assign M1_grant = r_grant[1];
    assign M2_grant = r_grant[2];
    assign M3_grant = r_grant[3];
    assign grant_id = r_grant_id;
    assign bus_busy = r_busy;

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb/tb_bus_arbiter4.sv - directed vector bench for bus_arbiter4
module tb_bus_arbiter4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       busy;
    int         n_pass;
    int         n_total;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vecs[15];

    bus_arbiter4 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .M0_req   (req[0]),
        .M1_req   (req[1]),
        .M2_req   (req[2]),
        .M3_req   (req[3]),
`ifdef BUS_ARB_LOCK_EN
        .M0_lock  (lock[0]),
        .M1_lock  (lock[1]),
        .M2_lock  (lock[2]),
        .M3_lock  (lock[3]),
`endif
        .M0_grant (gnt[0]),
        .M1_grant (gnt[1]),
        .M2_grant (gnt[2]),
        .M3_grant (gnt[3]),
        .grant_id (gid),
        .bus_busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] eid, input logic eb);
        n_total++;
        if (gnt === eg && gid === eid && busy === eb) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got grant=%b id=%0d busy=%b, expected grant=%b id=%0d busy=%b",
                     name, gnt, gid, busy, eg, eid, eb);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        req     = 4'b0000;
        lock    = 4'b0000;

        // {rst_n, req(M3..M0), grant(M3..M0), grant_id, busy} after the edge
        vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[3]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[6]  = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[7]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[9]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[11] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[12] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[13] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[14] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            reset_n = vecs[i].rst_n;
            req     = vecs[i].req;
            step();
            chk($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].busy);
        end

        // Tenure limit: M1 holds, M3 arrives in M1's 3rd granted cycle.
        req = 4'b0010;
        step();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("tenure_hold%0d", k), 4'b0010, 2'd1, 1'b1);
            if (k == 3) req = 4'b1010;
            step();
        end
        chk("tenure_switch", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        step();
        chk("tenure_idle", 4'b0000, 2'd3, 1'b0);

        // Saturation: M0 alone for 20 cycles, then M1 must win at once.
        req = 4'b0001;
        step();
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("sat_hold%0d", k), 4'b0001, 2'd0, 1'b1);
            step();
        end
        req = 4'b0011;
        step();
        chk("sat_switch", 4'b0010, 2'd1, 1'b1);

        // Reset while M3 owns with M1 pending.
        req = 4'b1000;
        step();
        chk("rst_m3_own", 4'b1000, 2'd3, 1'b1);
        req = 4'b1010;
        step();
        chk("rst_m3_hold", 4'b1000, 2'd3, 1'b1);
        reset_n = 1'b0;
        step();
        chk("rst_clear", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        step();
        chk("rst_m1_win", 4'b0010, 2'd1, 1'b1);

`ifdef BUS_ARB_LOCK_EN
        // M0 builds up tenure alone, then locks while M1 waits.
        req = 4'b0001;
        step();
        for (int k = 1; k <= 9; k++) step();
        chk("lock_m0_own", 4'b0001, 2'd0, 1'b1);
        lock = 4'b0001;
        req  = 4'b0011;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("lock_hold%0d", k), 4'b0001, 2'd0, 1'b1);
        end
        lock = 4'b0000;
        step();
        chk("lock_release", 4'b0010, 2'd1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
